// File: rtl/neuron_mac_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_mac_param_if
//  Brief    : Config bus, input stream and output stream of the neuron core.
//  Revision : 1.0  initial release
// ============================================================================
interface neuron_mac_param_if #(
  parameter int DATA_WIDTH = 16
);
  logic [31:0]           config_layer_num;
  logic [31:0]           config_neuron_num;
  logic                  weight_valid;
  logic [31:0]           weight_value;
  logic                  bias_valid;
  logic [31:0]           bias_value;
  logic [1:0]            act_mode;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  load_err;

  modport master (
    output config_layer_num, config_neuron_num, weight_valid, weight_value,
           bias_valid, bias_value, act_mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, load_err
  );

  modport slave (
    input  config_layer_num, config_neuron_num, weight_valid, weight_value,
           bias_valid, bias_value, act_mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, load_err
  );
endinterface
`default_nettype wire

// File: rtl/neuron_mac_param.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_mac_param
//  Brief    : Generic neuron core: loadable weights/bias, saturating MAC,
//             run-time activation, valid/ready streams with backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module neuron_mac_param #(
  parameter int LAYER_NO         = 1,
  parameter int NEURON_NO        = 0,
  parameter int NUM_WEIGHT       = 30,
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 1,
  parameter int SIGMOID_SIZE     = 10
) (
  input  logic                clk,
  input  logic                rst,
  neuron_mac_param_if.slave   bus
);

  localparam int c_ACC_W = 2 * DATA_WIDTH;
  localparam int c_PTR_W = $clog2(NUM_WEIGHT);
  localparam int c_CNT_W = $clog2(NUM_WEIGHT + 1);
  localparam logic [c_CNT_W-1:0]        c_CNT_FULL = c_CNT_W'(NUM_WEIGHT);
  localparam logic [c_PTR_W-1:0]        c_PTR_LAST = c_PTR_W'(NUM_WEIGHT - 1);
  localparam logic signed [c_ACC_W-1:0] c_ACC_MAX  = {1'b0, {(c_ACC_W-1){1'b1}}};
  localparam logic signed [c_ACC_W-1:0] c_ACC_MIN  = {1'b1, {(c_ACC_W-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0]     c_OUT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]     c_OUT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_DRAIN = 3'd2,
    S_BIAS  = 3'd3,
    S_ACT   = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t                        r_state;
  logic [c_CNT_W-1:0]            r_cnt;
  logic [c_PTR_W-1:0]            r_wptr;
  logic                          r_drain;
  logic signed [c_ACC_W-1:0]     r_bias;
  logic signed [c_ACC_W-1:0]     r_acc;
  logic                          r_load_err;
  logic [DATA_WIDTH-1:0]         r_out_data;
  logic                          r_out_valid;

  logic [DATA_WIDTH-1:0]         r_mem [NUM_WEIGHT];
  logic [c_PTR_W-1:0]            r_raddr;
  logic signed [DATA_WIDTH-1:0]  r_x1;
  logic signed [DATA_WIDTH-1:0]  r_x2;
  logic signed [DATA_WIDTH-1:0]  r_w2;
  logic signed [c_ACC_W-1:0]     r_prod;
  logic                          r_v1;
  logic                          r_v2;
  logic                          r_v3;

  logic                          w_sel;
  logic                          w_idle;
  logic                          w_xfer;
  logic                          w_wr_req;
  logic [DATA_WIDTH-1:0]         w_slice;
  logic [WEIGHT_INT_WIDTH:0]     w_top;
  logic                          w_fits;
  logic [DATA_WIDTH-1:0]         w_ident;
  logic [DATA_WIDTH-1:0]         w_act;
  logic                          w_unused_bits;

  function automatic logic signed [c_ACC_W-1:0] f_sat_add(
    input logic signed [c_ACC_W-1:0] a,
    input logic signed [c_ACC_W-1:0] b
  );
    logic signed [c_ACC_W-1:0] sum;
    sum = a + b;
    if (!a[c_ACC_W-1] && !b[c_ACC_W-1] && sum[c_ACC_W-1])
      return c_ACC_MAX;
    else if (a[c_ACC_W-1] && b[c_ACC_W-1] && !sum[c_ACC_W-1])
      return c_ACC_MIN;
    return sum;
  endfunction

  assign w_sel    = (bus.config_layer_num == 32'(LAYER_NO)) &&
                    (bus.config_neuron_num == 32'(NEURON_NO));
  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_req = w_sel && (bus.weight_valid || bus.bias_valid);
  // Held low combinationally while reset is asserted, not just after it.
  assign bus.in_ready = rst && (w_idle || ((r_state == S_ACCUM) && (r_cnt < c_CNT_FULL)));
  assign w_xfer   = bus.in_valid && bus.in_ready;

  assign w_slice  = r_acc[c_ACC_W-1-WEIGHT_INT_WIDTH -: DATA_WIDTH];
  assign w_top    = r_acc[c_ACC_W-1 -: WEIGHT_INT_WIDTH+1];
  assign w_fits   = (&w_top) || !(|w_top);
  assign w_ident  = w_fits ? w_slice : (r_acc[c_ACC_W-1] ? c_OUT_MIN : c_OUT_MAX);

  always_comb begin
    w_act = w_ident;
    case (bus.act_mode)
      2'd1:    w_act = r_acc[c_ACC_W-1] ? '0 : w_ident;
      2'd2:    w_act = DATA_WIDTH'(r_acc[c_ACC_W-1 -: SIGMOID_SIZE]);
      default: w_act = w_ident;
    endcase
  end

  assign w_unused_bits = ^{bus.weight_value, bus.bias_value};

  // Weight storage and datapath operands carry no reset; only valids do.
  always_ff @(posedge clk) begin
    if (w_idle && w_sel && bus.weight_valid)
      r_mem[r_wptr] <= bus.weight_value[DATA_WIDTH-1:0];
    if (w_xfer) begin
      r_raddr <= r_cnt[c_PTR_W-1:0];
      r_x1    <= bus.in_data;
    end
    r_w2   <= r_mem[r_raddr];
    r_x2   <= r_x1;
    r_prod <= c_ACC_W'(r_x2) * c_ACC_W'(r_w2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      r_v1 <= w_xfer;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_drain     <= 1'b0;
      r_bias      <= '0;
      r_acc       <= '0;
      r_load_err  <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_idle && w_sel && bus.weight_valid)
        r_wptr <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + c_PTR_W'(1);
      if (w_idle && w_sel && bus.bias_valid)
        r_bias <= bus.bias_value[c_ACC_W-1:0];
      if (!w_idle && w_wr_req)
        r_load_err <= 1'b1;
      if (r_v3)
        r_acc <= f_sat_add(r_acc, r_prod);

      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_cnt   <= r_cnt + c_CNT_W'(1);
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_xfer)
            r_cnt <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_CNT_FULL)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_drain <= ~r_drain;
          if (r_drain)
            r_state <= S_BIAS;
        end
        S_BIAS: begin
          r_acc   <= f_sat_add(r_acc, r_bias);
          r_state <= S_ACT;
        end
        S_ACT: begin
          r_out_data  <= w_act;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_mac_param
//  Brief    : Directed and randomized bench with an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_neuron_mac_param;
  localparam int NW  = 4;
  localparam int DW  = 16;
  localparam int WIW = 1;
  localparam int SIG = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_mac_param_if #(.DATA_WIDTH(DW)) bus ();

  neuron_mac_param #(
    .LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_WIDTH(DW),
    .WEIGHT_INT_WIDTH(WIW), .SIGMOID_SIZE(SIG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_mem [NW];
  logic [15:0] m_x   [NW];
  int          m_wptr = 0;
  longint      m_bias = 0;
  bit          m_err  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint f_sat(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Output scaling: drop DW-WIW fraction bits, then clamp to the output range.
  function automatic logic [15:0] f_act(input longint acc, input int mode);
    longint v;
    if (mode == 2) return 16'((acc >> (2*DW - SIG)) & ((64'd1 << SIG) - 1));
    v = acc >>> (DW - WIW);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    if (mode == 1 && acc < 0) v = 0;
    return 16'(v);
  endfunction

  task automatic wr_weight(input logic [15:0] v, input int layer);
    bus.config_layer_num  = 32'(layer);
    bus.config_neuron_num = 32'd0;
    bus.weight_value      = {16'($urandom), v};
    bus.weight_valid      = 1'b1;
    tick();
    bus.weight_valid      = 1'b0;
    bus.config_layer_num  = 32'd1;
    if (layer == 1) begin
      m_mem[m_wptr] = v;
      m_wptr = (m_wptr + 1) % NW;
    end
  endtask

  task automatic wr_bias(input logic [31:0] v, input int layer);
    bus.config_layer_num = 32'(layer);
    bus.bias_value       = v;
    bus.bias_valid       = 1'b1;
    tick();
    bus.bias_valid       = 1'b0;
    bus.config_layer_num = 32'd1;
    if (layer == 1) m_bias = longint'($signed(v));
  endtask

  task automatic load_w(input logic [15:0] v);
    for (int i = 0; i < NW; i++) wr_weight(v, 1);
  endtask

  task automatic set_x(input logic [15:0] v);
    for (int i = 0; i < NW; i++) m_x[i] = v;
  endtask

  task automatic run(input int gap, input int mode, input int stall, input bit poke);
    longint      acc;
    logic [15:0] exp;
    int          n;
    acc = 0;
    for (int i = 0; i < NW; i++)
      acc = f_sat(acc + longint'($signed(m_mem[i])) * longint'($signed(m_x[i])));
    acc = f_sat(acc + m_bias);
    exp = f_act(acc, mode);

    bus.act_mode  = 2'(mode);
    bus.out_ready = (stall == 0);
    for (int i = 0; i < NW; i++) begin
      bus.in_data  = m_x[i];
      bus.in_valid = 1'b1;
      if (poke && i == 1) begin
        bus.config_layer_num  = 32'd1;
        bus.config_neuron_num = 32'd0;
        bus.weight_value      = $urandom;
        bus.weight_valid      = 1'b1;
      end
      chk("in_ready_stream", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid     = 1'b0;
      bus.weight_valid = 1'b0;
      if (poke && i == 1) m_err = 1'b1;
      if (i < NW - 1)
        for (int g = 0; g < gap; g++) tick();
    end
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd5);
    chk("out_data", 32'(bus.out_data), 32'(exp));
    chk("load_err", 32'(bus.load_err), 32'(m_err));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'(exp));
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("back_to_idle", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.config_layer_num  = 32'd1;
    bus.config_neuron_num = 32'd0;
    bus.weight_valid = 1'b0;
    bus.weight_value = '0;
    bus.bias_valid   = 1'b0;
    bus.bias_value   = '0;
    bus.act_mode     = 2'd0;
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_load_err", 32'(bus.load_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic fixed-point product, then ignored writes to another layer.
    load_w(16'h4000);
    wr_bias(32'h0, 1);
    set_x(16'h2000);
    run(0, 0, 0, 1'b0);
    wr_weight(16'h1234, 2);
    wr_bias(32'h1234_5678, 2);
    run(0, 0, 0, 1'b0);

    // Negative result through identity and ReLU.
    wr_bias(32'hE000_0000, 1);
    set_x(16'h0000);
    run(0, 0, 0, 1'b0);
    run(0, 1, 0, 1'b0);

    // Accumulator saturation both ways.
    wr_bias(32'h0, 1);
    load_w(16'h7FFF);
    set_x(16'h7FFF);
    run(0, 0, 0, 1'b0);
    load_w(16'h8000);
    run(0, 0, 0, 1'b0);

    // Backpressure, then a gapped stream.
    load_w(16'h4000);
    set_x(16'h2000);
    run(0, 0, 10, 1'b0);
    run(3, 0, 0, 1'b0);

    // Write during ACCUM is dropped; memory stays intact.
    run(0, 0, 0, 1'b1);
    run(0, 0, 0, 1'b0);

    // Pointer wrap: fifth write lands on mem[0].
    wr_weight(16'h1000, 1);
    wr_weight(16'h2000, 1);
    wr_weight(16'h3000, 1);
    wr_weight(16'h4000, 1);
    wr_weight(16'h0800, 1);
    for (int i = 0; i < NW; i++) m_x[i] = 16'($urandom);
    run(1, 0, 0, 1'b0);

    // Reset in the middle of a stream.
    bus.act_mode = 2'd0;
    bus.in_data  = 16'h7000;
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_load_err", 32'(bus.load_err), 32'd0);
    m_wptr = 0;
    m_bias = 0;
    m_err  = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_idle", 32'(bus.in_ready), 32'd1);
    set_x(16'h7000);
    run(0, 0, 0, 1'b0);
    run(0, 2, 0, 1'b0);

    // Randomized inferences.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NW; i++) wr_weight(16'($urandom), 1);
      wr_bias((k % 2 == 0) ? $urandom : 32'($signed(16'($urandom))) <<< 8, 1);
      for (int i = 0; i < NW; i++) m_x[i] = 16'($urandom);
      run(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
